// File: rtl/evu_pkg.sv
// Shared types, address map helpers and privilege encoding for the event unit.
package evu_pkg;

    localparam int EVU_NUM_CH  = 4;
    localparam int EVU_NUM_PC  = 4;
    localparam int EVU_ASID_W  = 16;
    localparam int EVU_ID_W    = EVU_NUM_CH + 1;
    localparam int EVU_INFO_W  = $clog2(EVU_NUM_PC) + 2 + EVU_ASID_W;

    localparam int EVU_CTRL_ADDR  = 0;
    localparam int EVU_CHSEL_BASE = 1;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_U = 2'b00;

    typedef struct packed {
        logic [EVU_ID_W-1:0]   id;
        logic [EVU_INFO_W-1:0] info;
    } evu_beat_t;

    // Comparator LSW/MSW pairs start right after the channel selectors.
    function automatic int evu_cmp_base(input int num_ch);
        return EVU_CHSEL_BASE + num_ch;
    endfunction

    function automatic int evu_hi_base(input int num_ch, input int num_pc);
        return evu_cmp_base(num_ch) + 2 * num_pc;
    endfunction

    // The reserved encoding folds onto U so downstream never sees it.
    function automatic logic [1:0] evu_priv_enc(input logic [1:0] priv);
        case (priv)
            PRIV_M:  return PRIV_M;
            PRIV_S:  return PRIV_S;
            default: return PRIV_U;
        endcase
    endfunction

endpackage

// File: rtl/evu_out_stage.sv
// Output register with one coalescing pending slot and a saturating drop counter.
module evu_out_stage #(
    parameter int ID_W   = 5,
    parameter int INFO_W = 20,
    parameter int DROP_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              beat_valid,
    input  logic [ID_W-1:0]   beat_id,
    input  logic [INFO_W-1:0] beat_info,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ID_W-1:0]   out_id,
    output logic [INFO_W-1:0] out_info,
    output logic [DROP_W-1:0] drop_cnt
);

    logic              out_valid_r;
    logic [ID_W-1:0]   out_id_r;
    logic [INFO_W-1:0] out_info_r;
    logic              pend_valid_r;
    logic [ID_W-1:0]   pend_id_r;
    logic [INFO_W-1:0] pend_info_r;
    logic [DROP_W-1:0] drop_cnt_r;
    logic              free_s;
    logic              drop_sat_s;

    assign free_s     = !out_valid_r || out_ready;
    assign drop_sat_s = &drop_cnt_r;

    // Advance output/pending; while stalled, later beats merge into pending keeping its info.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r  <= 1'b0;
            out_id_r     <= '0;
            out_info_r   <= '0;
            pend_valid_r <= 1'b0;
            pend_id_r    <= '0;
            pend_info_r  <= '0;
            drop_cnt_r   <= '0;
        end else if (free_s) begin
            if (pend_valid_r) begin
                out_valid_r  <= 1'b1;
                out_id_r     <= pend_id_r;
                out_info_r   <= pend_info_r;
                pend_valid_r <= beat_valid;
                if (beat_valid) begin
                    pend_id_r   <= beat_id;
                    pend_info_r <= beat_info;
                end
            end else begin
                out_valid_r <= beat_valid;
                if (beat_valid) begin
                    out_id_r   <= beat_id;
                    out_info_r <= beat_info;
                end
            end
        end else if (beat_valid) begin
            if (!pend_valid_r) begin
                pend_valid_r <= 1'b1;
                pend_id_r    <= beat_id;
                pend_info_r  <= beat_info;
            end else begin
                pend_id_r <= pend_id_r | beat_id;
                if (!drop_sat_s) begin
                    drop_cnt_r <= drop_cnt_r + DROP_W'(1);
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_id    = out_id_r;
    assign out_info  = out_info_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: rtl/evu_multi.sv
// Event unit: selectable event channels plus committed-PC comparators feeding the SPU.
// Define EVU_PC_RANGE_EN to turn each comparator into an inclusive [CMP_k, HI_k] range.
module evu_multi
    import evu_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int NUM_EVENTS      = 16,
    parameter int NUM_PC          = 4,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int VLEN            = 64,
    parameter int ASID_WIDTH      = 16,
    parameter int CFG_AW          = 8,
    parameter int DROP_W          = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_EVENTS-1:0]             event_i,
    input  logic [NR_COMMIT_PORTS*VLEN-1:0]   commit_pc_i,
    input  logic [NR_COMMIT_PORTS-1:0]        commit_ack_i,
    input  logic [1:0]                        priv_lvl_i,
    input  logic [ASID_WIDTH-1:0]             asid_i,
    input  logic                              cfg_we_i,
    input  logic [CFG_AW-1:0]                 cfg_addr_i,
    input  logic [31:0]                       cfg_wdata_i,
    output logic [31:0]                       cfg_rdata_o,
    output logic                              evu_valid_o,
    input  logic                              evu_ready_i,
    output logic [NUM_CH:0]                   evu_id_o,
    output logic [$clog2(NUM_PC)+2+ASID_WIDTH-1:0] evu_info_o,
    output logic [DROP_W-1:0]                 drop_cnt_o
);

    localparam int SEL_W    = $clog2(NUM_EVENTS);
    localparam int IDX_W    = $clog2(NUM_PC);
    localparam int ID_W     = NUM_CH + 1;
    localparam int INFO_W   = IDX_W + 2 + ASID_WIDTH;
    localparam int CMP_BASE = evu_cmp_base(NUM_CH);
`ifdef EVU_PC_RANGE_EN
    localparam int HI_BASE  = evu_hi_base(NUM_CH, NUM_PC);
`endif

    logic [NUM_PC-1:0] ctrl_en_r;
    logic [31:0]       chsel_r [NUM_CH];
    logic [63:0]       cmp_r   [NUM_PC];
`ifdef EVU_PC_RANGE_EN
    logic [63:0]       hi_r    [NUM_PC];
`endif
    logic [31:0]       rdata_s;
    logic [NUM_CH-1:0] ch_s;
    logic [NUM_PC-1:0] cmp_hit_s;
    logic              pc_hit_s;
    logic [IDX_W-1:0]  pc_idx_s;
    logic [ID_W-1:0]   beat_id_s;
    logic [INFO_W-1:0] beat_info_s;

    // Config register file; the MSW halves only exist for 64-bit PCs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en_r <= '0;
            for (int c = 0; c < NUM_CH; c++) chsel_r[c] <= 32'h0;
            for (int k = 0; k < NUM_PC; k++) begin
                cmp_r[k] <= 64'h0;
`ifdef EVU_PC_RANGE_EN
                hi_r[k]  <= 64'h0;
`endif
            end
        end else if (cfg_we_i) begin
            if (cfg_addr_i == CFG_AW'(EVU_CTRL_ADDR)) ctrl_en_r <= cfg_wdata_i[NUM_PC-1:0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_addr_i == CFG_AW'(EVU_CHSEL_BASE + c)) chsel_r[c] <= cfg_wdata_i;
            end
            for (int k = 0; k < NUM_PC; k++) begin
                if (cfg_addr_i == CFG_AW'(CMP_BASE + 2 * k)) cmp_r[k][31:0] <= cfg_wdata_i;
                if ((VLEN == 64) && (cfg_addr_i == CFG_AW'(CMP_BASE + 2 * k + 1))) cmp_r[k][63:32] <= cfg_wdata_i;
`ifdef EVU_PC_RANGE_EN
                if (cfg_addr_i == CFG_AW'(HI_BASE + 2 * k)) hi_r[k][31:0] <= cfg_wdata_i;
                if ((VLEN == 64) && (cfg_addr_i == CFG_AW'(HI_BASE + 2 * k + 1))) hi_r[k][63:32] <= cfg_wdata_i;
`endif
            end
        end
    end

    // Read mux as an OR of address-qualified fields; unmapped addresses fall through to zero.
    always_comb begin
        rdata_s = 32'h0;
        rdata_s = rdata_s | ({32{cfg_addr_i == CFG_AW'(EVU_CTRL_ADDR)}} & 32'(ctrl_en_r));
        for (int c = 0; c < NUM_CH; c++) begin
            rdata_s = rdata_s | ({32{cfg_addr_i == CFG_AW'(EVU_CHSEL_BASE + c)}} & chsel_r[c]);
        end
        for (int k = 0; k < NUM_PC; k++) begin
            rdata_s = rdata_s | ({32{cfg_addr_i == CFG_AW'(CMP_BASE + 2 * k)}} & cmp_r[k][31:0]);
            rdata_s = rdata_s | ({32{(VLEN == 64) && (cfg_addr_i == CFG_AW'(CMP_BASE + 2 * k + 1))}} & cmp_r[k][63:32]);
`ifdef EVU_PC_RANGE_EN
            rdata_s = rdata_s | ({32{cfg_addr_i == CFG_AW'(HI_BASE + 2 * k)}} & hi_r[k][31:0]);
            rdata_s = rdata_s | ({32{(VLEN == 64) && (cfg_addr_i == CFG_AW'(HI_BASE + 2 * k + 1))}} & hi_r[k][63:32]);
`endif
        end
    end

    assign cfg_rdata_o = rdata_s;

    // Bits 30:0 form the selector so out-of-range values never alias onto a real event.
    always_comb begin
        ch_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_s[c] = chsel_r[c][31] && (chsel_r[c][30:0] < 31'(NUM_EVENTS))
                      && event_i[chsel_r[c][SEL_W-1:0]];
        end
    end

    // Per-comparator hit across all commit ports, then lowest index wins.
    always_comb begin
        cmp_hit_s = '0;
        pc_idx_s  = '0;
        for (int k = 0; k < NUM_PC; k++) begin
            for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
`ifdef EVU_PC_RANGE_EN
                cmp_hit_s[k] = cmp_hit_s[k] | (ctrl_en_r[k] & commit_ack_i[p]
                               & (commit_pc_i[p*VLEN +: VLEN] >= cmp_r[k][VLEN-1:0])
                               & (commit_pc_i[p*VLEN +: VLEN] <= hi_r[k][VLEN-1:0]));
`else
                cmp_hit_s[k] = cmp_hit_s[k] | (ctrl_en_r[k] & commit_ack_i[p]
                               & (commit_pc_i[p*VLEN +: VLEN] == cmp_r[k][VLEN-1:0]));
`endif
            end
        end
        for (int k = NUM_PC - 1; k >= 0; k--) begin
            pc_idx_s = cmp_hit_s[k] ? IDX_W'(k) : pc_idx_s;
        end
    end

    assign pc_hit_s    = |cmp_hit_s;
    assign beat_id_s   = {pc_hit_s, ch_s};
    assign beat_info_s = {pc_idx_s, evu_priv_enc(priv_lvl_i), asid_i};

    evu_out_stage #(
        .ID_W   (ID_W),
        .INFO_W (INFO_W),
        .DROP_W (DROP_W)
    ) u_out_stage (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .beat_valid (|beat_id_s),
        .beat_id    (beat_id_s),
        .beat_info  (beat_info_s),
        .out_ready  (evu_ready_i),
        .out_valid  (evu_valid_o),
        .out_id     (evu_id_o),
        .out_info   (evu_info_o),
        .drop_cnt   (drop_cnt_o)
    );

endmodule

// File: tb/tb_evu_multi.sv
// Self-checking bench for evu_multi: directed vectors plus random traffic against a queue model.
module tb_evu_multi;
    import evu_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [15:0]  event_i;
    logic [127:0] commit_pc_i;
    logic [1:0]   commit_ack_i;
    logic [1:0]   priv_lvl_i;
    logic [15:0]  asid_i;
    logic         cfg_we_i;
    logic [7:0]   cfg_addr_i;
    logic [31:0]  cfg_wdata_i;
    logic [31:0]  cfg_rdata_o;
    logic         evu_valid_o;
    logic         evu_ready_i;
    logic [4:0]   evu_id_o;
    logic [19:0]  evu_info_o;
    logic [15:0]  drop_cnt_o;

    evu_multi dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .event_i      (event_i),
        .commit_pc_i  (commit_pc_i),
        .commit_ack_i (commit_ack_i),
        .priv_lvl_i   (priv_lvl_i),
        .asid_i       (asid_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .evu_valid_o  (evu_valid_o),
        .evu_ready_i  (evu_ready_i),
        .evu_id_o     (evu_id_o),
        .evu_info_o   (evu_info_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: config image, queue of beats (head = output, second = pending), drop count.
    logic [3:0]  m_ctrl;
    logic [31:0] m_chsel [4];
    logic [63:0] m_cmp   [4];
    logic [63:0] m_hi    [4];
    evu_beat_t   m_q[$];
    logic [15:0] m_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_ctrl = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_chsel[i] = 32'h0; m_cmp[i] = 64'h0; m_hi[i] = 64'h0;
        end
        m_q.delete();
        m_drop = 16'h0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] addr);
        int a = int'(addr);
        if (a == 0) return {28'h0, m_ctrl};
        if (a >= 1 && a <= 4) return m_chsel[a-1];
        if (a >= 5 && a <= 12) return ((a - 5) % 2 == 1) ? m_cmp[(a-5)/2][63:32] : m_cmp[(a-5)/2][31:0];
`ifdef EVU_PC_RANGE_EN
        if (a >= 13 && a <= 20) return ((a - 13) % 2 == 1) ? m_hi[(a-13)/2][63:32] : m_hi[(a-13)/2][31:0];
`endif
        return 32'h0;
    endfunction

    task automatic m_write(input logic [7:0] addr, input logic [31:0] d);
        int a = int'(addr);
        if (a == 0) m_ctrl = d[3:0];
        else if (a >= 1 && a <= 4) m_chsel[a-1] = d;
        else if (a >= 5 && a <= 12) begin
            if ((a - 5) % 2 == 1) m_cmp[(a-5)/2][63:32] = d; else m_cmp[(a-5)/2][31:0] = d;
        end
`ifdef EVU_PC_RANGE_EN
        else if (a >= 13 && a <= 20) begin
            if ((a - 13) % 2 == 1) m_hi[(a-13)/2][63:32] = d; else m_hi[(a-13)/2][31:0] = d;
        end
`endif
    endtask

    function automatic bit m_pc_match(input int k, input logic [63:0] pc);
`ifdef EVU_PC_RANGE_EN
        return (pc >= m_cmp[k]) && (pc <= m_hi[k]);
`else
        return pc == m_cmp[k];
`endif
    endfunction

    function automatic evu_beat_t m_beat();
        evu_beat_t b;
        int        hit_k = -1;
        logic [1:0] idx;
        logic [1:0] prv;
        b.id = 5'h0;
        for (int c = 0; c < 4; c++) begin
            int sel = int'(m_chsel[c][30:0]);
            if (m_chsel[c][31] && sel < 16 && event_i[sel]) b.id[c] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (hit_k < 0 && m_ctrl[k] && commit_ack_i[p] && m_pc_match(k, commit_pc_i[p*64 +: 64]))
                    hit_k = k;
            end
        end
        b.id[4] = (hit_k >= 0);
        idx = (hit_k >= 0) ? 2'(hit_k) : 2'd0;
        prv = (priv_lvl_i == 2'b11) ? 2'b11 : (priv_lvl_i == 2'b01) ? 2'b01 : 2'b00;
        b.info = {idx, prv, asid_i};
        return b;
    endfunction

    // Model one clock edge from the inputs currently driven.
    task automatic m_clock();
        evu_beat_t b = m_beat();
        bit has = (b.id != 5'h0);
        if (m_q.size() == 0 || evu_ready_i) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (has) m_q.push_back(b);
        end else if (has) begin
            if (m_q.size() == 1) m_q.push_back(b);
            else begin
                evu_beat_t t = m_q[1];
                t.id = t.id | b.id;
                m_q[1] = t;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
        if (cfg_we_i) m_write(cfg_addr_i, cfg_wdata_i);
    endtask

    task automatic step(input bit chk);
        m_clock();
        @(posedge clk_i);
        #1;
        cfg_we_i = 1'b0;
        if (chk) begin
            check("valid", 64'(evu_valid_o), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check("id", 64'(evu_id_o), 64'(m_q[0].id));
                check("info", 64'(evu_info_o), 64'(m_q[0].info));
            end
            check("drop", 64'(drop_cnt_o), 64'(m_drop));
        end
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
        step(1'b1);
    endtask

    typedef struct {
        logic [15:0] ev;
        logic [1:0]  prv;
        logic        exp_v;
        logic [4:0]  exp_id;
        logic [1:0]  exp_prv;
    } vec_t;

    vec_t vt[6];
    logic [63:0] rng_pc[4];
    logic [3:0]  rng_exp;
    logic [15:0] d0;

    initial begin
        vt[0] = '{16'h0008, 2'b11, 1'b1, 5'b00001, 2'b11};
        vt[1] = '{16'h0020, 2'b01, 1'b1, 5'b00010, 2'b01};
        vt[2] = '{16'h0200, 2'b00, 1'b1, 5'b00100, 2'b00};
        vt[3] = '{16'h8000, 2'b10, 1'b1, 5'b01000, 2'b00};
        vt[4] = '{16'h8228, 2'b11, 1'b1, 5'b01111, 2'b11};
        vt[5] = '{16'h7DD7, 2'b01, 1'b0, 5'b00000, 2'b00};
        rng_pc[0] = 64'hFF; rng_pc[1] = 64'h100; rng_pc[2] = 64'h1FF; rng_pc[3] = 64'h200;
`ifdef EVU_PC_RANGE_EN
        rng_exp = 4'b0110;
`else
        rng_exp = 4'b0010;
`endif

        rst_ni = 1'b0; event_i = 16'h0; commit_pc_i = 128'h0; commit_ack_i = 2'b00;
        priv_lvl_i = 2'b00; asid_i = 16'h0; cfg_we_i = 1'b0; cfg_addr_i = 8'h0;
        cfg_wdata_i = 32'h0; evu_ready_i = 1'b1;
        m_reset();
        #12;
        check("rst_valid", 64'(evu_valid_o), 64'h0);
        check("rst_id", 64'(evu_id_o), 64'h0);
        check("rst_info", 64'(evu_info_o), 64'h0);
        check("rst_drop", 64'(drop_cnt_o), 64'h0);
        check("rst_ctrl", 64'(cfg_rdata_o), 64'h0);
        @(negedge clk_i) rst_ni = 1'b1;

        // Single channel pulse, latency one cycle.
        cfg_write(8'd1, 32'h8000_0003);
        event_i = 16'h0008; step(1'b1);
        check("t1_valid", 64'(evu_valid_o), 64'h1);
        check("t1_id", 64'(evu_id_o), 64'h01);
        event_i = 16'h0; step(1'b1);
        check("t1_drop_valid", 64'(evu_valid_o), 64'h0);

        cfg_write(8'd2, 32'h8000_0005);
        cfg_write(8'd3, 32'h8000_0009);
        cfg_write(8'd4, 32'h8000_000F);
        asid_i = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            event_i = vt[i].ev; priv_lvl_i = vt[i].prv;
            step(1'b1);
            check($sformatf("vec%0d_valid", i), 64'(evu_valid_o), 64'(vt[i].exp_v));
            check($sformatf("vec%0d_id", i), 64'(evu_id_o & {5{evu_valid_o}}), 64'(vt[i].exp_id));
            if (vt[i].exp_v) begin
                check($sformatf("vec%0d_priv", i), 64'(evu_info_o[17:16]), 64'(vt[i].exp_prv));
                check($sformatf("vec%0d_asid", i), 64'(evu_info_o[15:0]), 64'h1234);
            end
            event_i = 16'h0; step(1'b1);
        end

        // PC comparator 1 hit on commit port 1 in M-mode.
        cfg_write(8'd0, 32'h2);
        cfg_write(8'd7, 32'h8000_1000);
        cfg_write(8'd8, 32'h0);
        commit_pc_i = {64'h0000_0000_8000_1000, 64'h0};
        commit_ack_i = 2'b10; priv_lvl_i = 2'b11;
        step(1'b1);
        check("t2_pchit", 64'(evu_id_o[4]), 64'h1);
        check("t2_idx", 64'(evu_info_o[19:18]), 64'h1);
        check("t2_priv", 64'(evu_info_o[17:16]), 64'h3);
        commit_ack_i = 2'b00; step(1'b1);

        // Stall: ch0 held on output, ch1|ch2 coalesced in pending.
        d0 = m_drop;
        evu_ready_i = 1'b0;
        event_i = 16'h0008; step(1'b1);
        event_i = 16'h0020; step(1'b1);
        event_i = 16'h0200; step(1'b1);
        event_i = 16'h0;
        check("t3_hold_id", 64'(evu_id_o), 64'h01);
        check("t3_drop", 64'(drop_cnt_o), 64'(d0 + 16'd1));
        evu_ready_i = 1'b1; step(1'b1);
        check("t3_second_id", 64'(evu_id_o), 64'h06);
        check("t3_second_valid", 64'(evu_valid_o), 64'h1);
        step(1'b1);
        check("t3_empty", 64'(evu_valid_o), 64'h0);

        // Comparator 0 range/equality boundaries.
        cfg_write(8'd0, 32'h1);
        cfg_write(8'd5, 32'h100);
        cfg_write(8'd6, 32'h0);
        cfg_write(8'd13, 32'h1FF);
        cfg_write(8'd14, 32'h0);
        cfg_addr_i = 8'd13; #1;
`ifdef EVU_PC_RANGE_EN
        check("hi_readback", 64'(cfg_rdata_o), 64'h1FF);
`else
        check("hi_unmapped", 64'(cfg_rdata_o), 64'h0);
`endif
        for (int i = 0; i < 4; i++) begin
            commit_pc_i = {64'h0, rng_pc[i]}; commit_ack_i = 2'b01;
            step(1'b1);
            check($sformatf("range_pc%0h", rng_pc[i]), 64'(evu_id_o[4] & evu_valid_o), 64'(rng_exp[i]));
            commit_ack_i = 2'b00; step(1'b1);
        end

        // Out-of-range selector never fires and reads back verbatim.
        cfg_write(8'd1, 32'h8000_001F);
        event_i = 16'hFFFF; step(1'b1);
        check("t5_ch0_off", 64'(evu_id_o[0]), 64'h0);
        check("t5_id", 64'(evu_id_o), 64'h0E);
        event_i = 16'h0; step(1'b1);
        cfg_addr_i = 8'd1; #1;
        check("t5_readback", 64'(cfg_rdata_o), 64'h8000_001F);

        // Reset while stalled with a pending beat.
        evu_ready_i = 1'b0;
        event_i = 16'h0020; step(1'b1);
        event_i = 16'h0200; step(1'b1);
        event_i = 16'h0;
        rst_ni = 1'b0; #1;
        check("midrst_valid", 64'(evu_valid_o), 64'h0);
        check("midrst_id", 64'(evu_id_o), 64'h0);
        check("midrst_drop", 64'(drop_cnt_o), 64'h0);
        check("midrst_cfg", 64'(cfg_rdata_o), 64'h0);
        m_reset();
        @(negedge clk_i) rst_ni = 1'b1;
        evu_ready_i = 1'b1; step(1'b1);
        check("midrst_no_pending", 64'(evu_valid_o), 64'h0);

        // Random configuration and traffic.
        cfg_write(8'd0, 32'($urandom_range(0, 15)));
        for (int c = 0; c < 4; c++)
            cfg_write(8'(1 + c), {1'($urandom_range(0, 3) != 0), 26'h0, 5'($urandom_range(0, 19))});
        for (int k = 0; k < 4; k++) begin
            logic [63:0] lo = {$urandom, $urandom};
            logic [63:0] hi = lo + 64'($urandom_range(0, 64));
            cfg_write(8'(5 + 2*k), lo[31:0]);
            cfg_write(8'(6 + 2*k), lo[63:32]);
            cfg_write(8'(13 + 2*k), hi[31:0]);
            cfg_write(8'(14 + 2*k), hi[63:32]);
        end
        for (int n = 0; n < 600; n++) begin
            event_i = 16'($urandom & $urandom);
            commit_ack_i = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                int r = $urandom_range(0, 3);
                int k = $urandom_range(0, 3);
                if (r == 0) commit_pc_i[p*64 +: 64] = m_cmp[k];
                else if (r == 1) commit_pc_i[p*64 +: 64] = m_cmp[k] + 64'($urandom_range(0, 3));
                else commit_pc_i[p*64 +: 64] = {$urandom, $urandom};
            end
            priv_lvl_i = 2'($urandom); asid_i = 16'($urandom);
            evu_ready_i = ($urandom_range(0, 3) != 0);
            cfg_addr_i = 8'($urandom_range(0, 23));
            if ($urandom_range(0, 15) == 0) begin
                cfg_we_i = 1'b1; cfg_wdata_i = $urandom;
            end
            step(1'b1);
            check("rand_rdata", 64'(cfg_rdata_o), 64'(m_read(cfg_addr_i)));
        end

        // Drive merges until the drop counter saturates.
        commit_ack_i = 2'b00; event_i = 16'h0; evu_ready_i = 1'b1;
        cfg_write(8'd1, 32'h8000_0003);
        step(1'b1);
        evu_ready_i = 1'b0; event_i = 16'h0008;
        for (int g = 0; g < 70000 && m_drop < 16'hFFFE; g++) step(1'b0);
        check("drop_pre_sat", 64'(drop_cnt_o), 64'hFFFE);
        step(1'b1);
        check("drop_sat", 64'(drop_cnt_o), 64'hFFFF);
        step(1'b1);
        check("drop_hold", 64'(drop_cnt_o), 64'hFFFF);
        check("drop_hold_id", 64'(evu_id_o), 64'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
